// File: rtl/mod_keyfetch.sv
// Key-ROM fetch sequencer: walks the round-key ROM and streams keys on a valid/ready port.
// Define KEYFETCH_PREFETCH_EN for a two-entry prefetch buffer; default is a single key register.
module mod_keyfetch #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned NUM_KEYS   = 15
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  output logic                  rom_startBit,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_wr_en,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] key_out,
  output logic [ADDR_WIDTH-1:0] key_round,
  output logic                  key_valid,
  input  logic                  key_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LastKey = ADDR_WIDTH'(NUM_KEYS - 1);

  logic                  r_rom_en;
  logic                  r_rom_wr_en;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  logic [DATA_WIDTH-1:0] r_key_out;
  logic [ADDR_WIDTH-1:0] r_key_round;
  logic                  r_key_valid;
  logic                  r_busy;
  logic                  r_done;

  assign rom_startBit = r_rom_en;
  assign rom_addr     = r_rom_addr;
  assign rom_wr_en    = r_rom_wr_en;
  assign key_out      = r_key_out;
  assign key_round    = r_key_round;
  assign key_valid    = r_key_valid;
  assign busy         = r_busy;
  assign done         = r_done;

`ifdef KEYFETCH_PREFETCH_EN

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e                r_state;
  logic                  r_rd_cap;
  logic                  r_fetch_all;
  logic [ADDR_WIDTH-1:0] r_next_addr;
  logic                  r_buf_valid;
  logic [DATA_WIDTH-1:0] r_buf_data;
  logic [ADDR_WIDTH-1:0] r_buf_round;

  logic       w_xfer;
  logic       w_out_free;
  logic [1:0] w_occ;
  logic       w_issue;

  // Keys held or in flight after this edge; a new strobe is only allowed if it keeps that <= 2.
  always_comb begin
    w_xfer     = r_key_valid && key_ready;
    w_out_free = !r_key_valid || w_xfer;
    w_occ      = {1'b0, r_key_valid} + {1'b0, r_buf_valid} + {1'b0, r_rd_cap} - {1'b0, w_xfer};
    w_issue    = (r_state == StRun) && !r_fetch_all && !r_rom_wr_en && (w_occ < 2'd2);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= StIdle;
      r_rom_en    <= 1'b0;
      r_rom_wr_en <= 1'b0;
      r_rom_addr  <= '0;
      r_key_out   <= '0;
      r_key_round <= '0;
      r_key_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_cap    <= 1'b0;
      r_fetch_all <= 1'b0;
      r_next_addr <= '0;
      r_buf_valid <= 1'b0;
      r_buf_data  <= '0;
      r_buf_round <= '0;
    end else begin
      r_rom_wr_en <= 1'b0;
      r_done      <= 1'b0;
      r_rd_cap    <= r_rom_wr_en;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state     <= StRun;
            r_busy      <= 1'b1;
            r_rom_en    <= 1'b1;
            r_rom_wr_en <= 1'b1;
            r_rom_addr  <= '0;
            r_next_addr <= ADDR_WIDTH'(1);
            r_fetch_all <= (LastKey == '0);
          end
        end
        StRun: begin
          if (w_issue) begin
            r_rom_wr_en <= 1'b1;
            r_rom_addr  <= r_next_addr;
            if (r_next_addr == LastKey) begin
              r_fetch_all <= 1'b1;
            end else begin
              r_next_addr <= r_next_addr + 1'b1;
            end
          end
          // r_rom_addr still names the read whose data is on rom_data while r_rd_cap is high.
          if (w_out_free) begin
            if (r_buf_valid) begin
              r_key_out   <= r_buf_data;
              r_key_round <= r_buf_round;
              r_key_valid <= 1'b1;
              r_buf_valid <= r_rd_cap;
              if (r_rd_cap) begin
                r_buf_data  <= rom_data;
                r_buf_round <= r_rom_addr;
              end
            end else if (r_rd_cap) begin
              r_key_out   <= rom_data;
              r_key_round <= r_rom_addr;
              r_key_valid <= 1'b1;
            end else begin
              r_key_valid <= 1'b0;
            end
          end else if (r_rd_cap) begin
            r_buf_data  <= rom_data;
            r_buf_round <= r_rom_addr;
            r_buf_valid <= 1'b1;
          end
          if (w_xfer && (r_key_round == LastKey)) begin
            r_done  <= 1'b1;
            r_state <= StFin;
          end
        end
        StFin: begin
          r_busy   <= 1'b0;
          r_rom_en <= 1'b0;
          r_state  <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`else

  typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StFin} state_e;

  state_e r_state;

  // r_rom_addr doubles as the fetch counter; it is only ever advanced below LastKey.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= StIdle;
      r_rom_en    <= 1'b0;
      r_rom_wr_en <= 1'b0;
      r_rom_addr  <= '0;
      r_key_out   <= '0;
      r_key_round <= '0;
      r_key_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_rom_wr_en <= 1'b0;
      r_done      <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state     <= StReq;
            r_busy      <= 1'b1;
            r_rom_en    <= 1'b1;
            r_rom_wr_en <= 1'b1;
            r_rom_addr  <= '0;
          end
        end
        StReq: begin
          r_state <= StWait;
        end
        StWait: begin
          r_key_out   <= rom_data;
          r_key_round <= r_rom_addr;
          r_key_valid <= 1'b1;
          r_state     <= StHold;
        end
        StHold: begin
          if (key_ready) begin
            r_key_valid <= 1'b0;
            if (r_rom_addr == LastKey) begin
              r_done  <= 1'b1;
              r_state <= StFin;
            end else begin
              r_rom_addr  <= r_rom_addr + 1'b1;
              r_rom_wr_en <= 1'b1;
              r_state     <= StReq;
            end
          end
        end
        StFin: begin
          r_busy   <= 1'b0;
          r_rom_en <= 1'b0;
          r_state  <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_mod_keyfetch.sv
// Directed bench for mod_keyfetch: reset, full run, backpressure, ignored start,
// reset mid-run, and a NUM_KEYS=1 instance.
module tb_mod_keyfetch;

  localparam int DW = 128;
  localparam int AW = 4;
  localparam int NK = 15;
`ifdef KEYFETCH_PREFETCH_EN
  localparam int DoneLat = 31;
`else
  localparam int DoneLat = 45;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          start = 1'b0;
  logic          key_ready = 1'b0;
  logic          rom_startBit, rom_wr_en, key_valid, busy, done;
  logic [AW-1:0] rom_addr, key_round;
  logic [DW-1:0] rom_data, key_out;

  logic          s1_start = 1'b0;
  logic          s1_ready = 1'b1;
  logic          s1_startBit, s1_wr_en, s1_valid, s1_busy, s1_done;
  logic [AW-1:0] s1_addr, s1_round;
  logic [DW-1:0] s1_rom_data, s1_key;

  always #5 clk = ~clk;

  mod_keyfetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_KEYS(NK)) u_dut (
    .clk(clk), .resetn(resetn), .start(start), .rom_startBit(rom_startBit),
    .rom_addr(rom_addr), .rom_wr_en(rom_wr_en), .rom_data(rom_data), .key_out(key_out),
    .key_round(key_round), .key_valid(key_valid), .key_ready(key_ready), .busy(busy),
    .done(done)
  );

  mod_keyfetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_KEYS(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .start(s1_start), .rom_startBit(s1_startBit),
    .rom_addr(s1_addr), .rom_wr_en(s1_wr_en), .rom_data(s1_rom_data), .key_out(s1_key),
    .key_round(s1_round), .key_valid(s1_valid), .key_ready(s1_ready), .busy(s1_busy),
    .done(s1_done)
  );

  function automatic logic [DW-1:0] exp_key(input int n);
    logic [7:0] b;
    b = {n[3:0], 4'hA};
    return {16{b}};
  endfunction

  // ROM: data for the strobed address appears the cycle after the strobe and holds.
  always @(posedge clk) begin
    if (rom_wr_en) rom_data <= exp_key(int'(rom_addr));
    if (s1_wr_en) s1_rom_data <= exp_key(int'(s1_addr));
  end

  int            errors = 0;
  int            checks = 0;
  int            xfer_round[$];
  logic [DW-1:0] xfer_data[$];
  int            strobes, dones, sep_viol, max_addr;
  logic          prev_wr = 1'b0;
  int            s1_xfers, s1_strobes, s1_dones, s1_max_addr, s1_xround;
  logic [DW-1:0] s1_xdata;

  always @(negedge clk) begin
    if (key_valid && key_ready) begin
      xfer_round.push_back(int'(key_round));
      xfer_data.push_back(key_out);
    end
    if (rom_wr_en) begin
      strobes++;
      if (prev_wr) sep_viol++;
      if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
    end
    prev_wr = rom_wr_en;
    if (done) dones++;
    if (s1_valid && s1_ready) begin
      s1_xfers++;
      s1_xround = int'(s1_round);
      s1_xdata  = s1_key;
    end
    if (s1_wr_en) begin
      s1_strobes++;
      if (int'(s1_addr) > s1_max_addr) s1_max_addr = int'(s1_addr);
    end
    if (s1_done) s1_dones++;
  end

  task automatic clear_logs();
    xfer_round.delete();
    xfer_data.delete();
    strobes = 0; dones = 0; sep_viol = 0; max_addr = 0;
    s1_xfers = 0; s1_strobes = 0; s1_dones = 0; s1_max_addr = 0; s1_xround = -1;
    s1_xdata = '0;
  endtask

  // Returns just after the edge that samples start (E0).
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      n++;
    end
  endtask

  task automatic wait_round(input int r, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if (key_valid && int'(key_round) == r) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #3 resetn = 1'b0;
    #1;
    checks++;
    if ({rom_startBit, rom_addr, rom_wr_en, key_out, key_round, key_valid, busy, done} !== '0)
      begin errors++; $display("FAIL reset_outputs: got busy=%b valid=%b wr=%b addr=%0d key=%0h",
        busy, key_valid, rom_wr_en, rom_addr, key_out); end
    checks++;
    if ({s1_startBit, s1_addr, s1_wr_en, s1_key, s1_round, s1_valid, s1_busy, s1_done} !== '0)
      begin errors++; $display("FAIL reset_outputs_n1: got busy=%b valid=%b", s1_busy, s1_valid); end
    clear_logs();
    key_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (strobes !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_hold: got strobes=%0d busy=%b expected 0 0", strobes, busy);
    end
    @(posedge clk); #1 resetn = 1'b1;
  endtask

  task automatic test_basic();
    int n;
    bit ok;
    clear_logs();
    key_ready = 1'b1;
    pulse_start();
    @(negedge clk);
    checks++;
    if (!(busy === 1'b1 && rom_startBit === 1'b1 && rom_wr_en === 1'b1 && rom_addr === '0 &&
          key_valid === 1'b0)) begin
      errors++; $display("FAIL basic_after_e0: got busy=%b en=%b wr=%b addr=%0d valid=%b expected 1 1 1 0 0",
        busy, rom_startBit, rom_wr_en, rom_addr, key_valid);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (rom_wr_en !== 1'b0 || key_valid !== 1'b0) begin
      errors++; $display("FAIL basic_after_e1: got wr=%b valid=%b expected 0 0", rom_wr_en, key_valid);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (key_valid !== 1'b1 || key_round !== 4'd0 || key_out !== exp_key(0)) begin
      errors++; $display("FAIL basic_key0_latency: got valid=%b round=%0d key=%0h expected 1 0 %0h",
        key_valid, key_round, key_out, exp_key(0));
    end
    @(posedge clk);
    wait_done(200, n, ok);
    checks++;
    if (!ok || n + 3 != DoneLat) begin
      errors++; $display("FAIL basic_done_latency: got ok=%0d cycles=%0d expected %0d", ok, n + 3, DoneLat);
    end
    @(posedge clk); @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rom_startBit !== 1'b0 || dones != 1) begin
      errors++; $display("FAIL basic_end_state: got busy=%b done=%b en=%b dones=%0d expected 0 0 0 1",
        busy, done, rom_startBit, dones);
    end
    checks++;
    if (strobes != NK || sep_viol != 0 || max_addr != NK - 1) begin
      errors++; $display("FAIL basic_strobes: got strobes=%0d adjacent=%0d max_addr=%0d expected %0d 0 %0d",
        strobes, sep_viol, max_addr, NK, NK - 1);
    end
    checks++;
    if (xfer_round.size() != NK) begin
      errors++; $display("FAIL basic_xfer_count: got %0d expected %0d", xfer_round.size(), NK);
    end
    for (int i = 0; i < xfer_round.size() && i < NK; i++) begin
      checks++;
      if (xfer_round[i] != i || xfer_data[i] !== exp_key(i)) begin
        errors++; $display("FAIL basic_key[%0d]: got round=%0d key=%0h expected round=%0d key=%0h",
          i, xfer_round[i], xfer_data[i], i, exp_key(i));
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    int s0;
    bit ok;
    clear_logs();
    key_ready = 1'b1;
    pulse_start();
    wait_round(2, 40, ok);
    @(posedge clk); #1 key_ready = 1'b0;
    wait_round(3, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_key3_arrive: got no key 3 expected key 3 valid"); end
    s0 = strobes;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk); #1;
      checks++;
      if (key_valid !== 1'b1 || key_round !== 4'd3 || key_out !== exp_key(3)) begin
        errors++; $display("FAIL bp_hold[%0d]: got valid=%b round=%0d key=%0h expected 1 3 %0h",
          i, key_valid, key_round, key_out, exp_key(3));
      end
    end
    checks++;
`ifdef KEYFETCH_PREFETCH_EN
    if (strobes - s0 > 1 || strobes > 3 + 2) begin
`else
    if (strobes - s0 != 0) begin
`endif
      errors++; $display("FAIL bp_no_fetch: got %0d extra strobes during stall", strobes - s0);
    end
    @(posedge clk); #1 key_ready = 1'b1;
    wait_done(200, n, ok);
    @(posedge clk); @(negedge clk); #1;
    checks++;
    if (!ok || dones != 1 || xfer_round.size() != NK) begin
      errors++; $display("FAIL bp_complete: got ok=%0d dones=%0d xfers=%0d expected 1 1 %0d",
        ok, dones, xfer_round.size(), NK);
    end
    for (int i = 0; i < xfer_round.size() && i < NK; i++) begin
      checks++;
      if (xfer_round[i] != i || xfer_data[i] !== exp_key(i)) begin
        errors++; $display("FAIL bp_key[%0d]: got round=%0d expected %0d", i, xfer_round[i], i);
      end
    end
  endtask

  task automatic test_ignored_start();
    int n;
    bit ok;
    clear_logs();
    key_ready = 1'b1;
    pulse_start();
    wait_round(5, 60, ok);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(200, n, ok);
    repeat (6) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (!ok || dones != 1 || busy !== 1'b0 || strobes != NK) begin
      errors++; $display("FAIL ign_start: got ok=%0d dones=%0d busy=%b strobes=%0d expected 1 1 0 %0d",
        ok, dones, busy, strobes, NK);
    end
    checks++;
    if (xfer_round.size() != NK) begin
      errors++; $display("FAIL ign_xfer_count: got %0d expected %0d", xfer_round.size(), NK);
    end
    for (int i = 0; i < xfer_round.size() && i < NK; i++) begin
      checks++;
      if (xfer_round[i] != i || xfer_data[i] !== exp_key(i)) begin
        errors++; $display("FAIL ign_key[%0d]: got round=%0d expected %0d", i, xfer_round[i], i);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int s0;
    bit ok;
    clear_logs();
    key_ready = 1'b1;
    pulse_start();
    wait_round(7, 60, ok);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({rom_startBit, rom_addr, rom_wr_en, key_out, key_round, key_valid, busy, done} !== '0)
      begin errors++; $display("FAIL rstmid_async: got busy=%b valid=%b round=%0d key=%0h expected all 0",
        busy, key_valid, key_round, key_out); end
    s0 = strobes;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (strobes != s0 || busy !== 1'b0 || key_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_quiet: got strobes+%0d busy=%b valid=%b expected 0 0 0",
        strobes - s0, busy, key_valid);
    end
    @(posedge clk); #1 resetn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (strobes != s0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_no_restart: got strobes+%0d busy=%b expected 0 0", strobes - s0, busy);
    end
    clear_logs();
    pulse_start();
    wait_done(200, n, ok);
    @(posedge clk); @(negedge clk); #1;
    checks++;
    if (!ok || dones != 1 || xfer_round.size() != NK) begin
      errors++; $display("FAIL rstmid_rerun: got ok=%0d dones=%0d xfers=%0d expected 1 1 %0d",
        ok, dones, xfer_round.size(), NK);
    end
    for (int i = 0; i < xfer_round.size() && i < NK; i++) begin
      checks++;
      if (xfer_round[i] != i || xfer_data[i] !== exp_key(i)) begin
        errors++; $display("FAIL rstmid_key[%0d]: got round=%0d expected %0d", i, xfer_round[i], i);
      end
    end
  endtask

  task automatic test_num_keys1();
    int n;
    bit ok;
    clear_logs();
    @(posedge clk); #1 s1_start = 1'b1;
    @(posedge clk); #1 s1_start = 1'b0;
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s1_done) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      n++;
    end
    checks++;
    if (!ok || n != 3) begin
      errors++; $display("FAIL n1_done_latency: got ok=%0d cycles=%0d expected 1 3", ok, n);
    end
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (s1_xfers != 1 || s1_xround != 0 || s1_xdata !== exp_key(0)) begin
      errors++; $display("FAIL n1_xfer: got xfers=%0d round=%0d key=%0h expected 1 0 %0h",
        s1_xfers, s1_xround, s1_xdata, exp_key(0));
    end
    checks++;
    if (s1_strobes != 1 || s1_max_addr != 0 || s1_dones != 1 || s1_busy !== 1'b0) begin
      errors++; $display("FAIL n1_fetch: got strobes=%0d max_addr=%0d dones=%0d busy=%b expected 1 0 1 0",
        s1_strobes, s1_max_addr, s1_dones, s1_busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ignored_start();
    test_reset_mid();
    test_num_keys1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/mod_keyfetch.md
# mod_keyFetch

Sequencer between `mod_romKey` and the AES-256 round datapath. On a start pulse it walks the key ROM from address 0 to `NUM_KEYS-1`, drives the ROM enable, address and read strobe, and captures each 128-bit round key. It presents each key downstream on a valid/ready handshake, in order, tagged with its round index. It signals completion after the last key is accepted.

## Interface
Parameters:
- `DATA_WIDTH`, 128, round-key width; matches ROM data width.
- `ADDR_WIDTH`, 4, ROM address width.
- `NUM_KEYS`, 15, keys to fetch (AES-256 rounds 0..14); legal range 1..2^ADDR_WIDTH.

Ports:
- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse; begins a fetch sequence; ignored while `busy`.
- `rom_startBit`  out  1  ROM enable; high from the cycle after an accepted `start` until `done`.
- `rom_addr`  out  ADDR_WIDTH  ROM address being read.
- `rom_wr_en`  out  1  ROM read strobe; one-cycle pulse per key.
- `rom_data`  in  DATA_WIDTH  ROM output.
- `key_out`  out  DATA_WIDTH  current round key.
- `key_round`  out  ADDR_WIDTH  index of `key_out`.
- `key_valid`  out  1  `key_out`/`key_round` valid.
- `key_ready`  in  1  consumer accepts.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle pulse after last key accepted.

## Operation
- **ROM contract:** `rom_data` for `rom_addr` is valid in the cycle after the cycle where `rom_wr_en=1` was sampled. It holds until the next strobe.
- **FSM states:** IDLE, REQ, WAIT, HOLD, FIN.
  - IDLE: on `start`, `addr_cnt<=0`, go to REQ.
  - REQ: `rom_wr_en=1`, `rom_addr=addr_cnt`; go to WAIT.
  - WAIT: `rom_wr_en=0`; at the cycle end, capture `rom_data` into `key_out` and `addr_cnt` into `key_round`, set `key_valid`; go to HOLD.
  - HOLD: wait for `key_valid && key_ready` at a rising edge (transfer). On transfer, if `addr_cnt==NUM_KEYS-1`, go to FIN; otherwise increment `addr_cnt` and go to REQ.
  - FIN: pulse `done`, drop `busy` and `rom_startBit`; go to IDLE.
- **Handshake:**
  - `key_valid` never drops without a transfer.
  - `key_out`/`key_round` are stable while valid.
  - `key_ready` may be asserted at any time, including before valid.
- **Idle outputs:** after a transfer, `key_valid=0`. `key_out`/`key_round` keep their last value.
- **`start` while busy:** ignored; no restart, no queuing.
- **Reset mid-sequence:** all outputs return to their reset values immediately (asynchronous). No further ROM strobes are issued. A new `start` is required.
- **Counter:** `addr_cnt` is ADDR_WIDTH bits and never wraps past `NUM_KEYS-1`.

## Timing
- **Reset values:**
  - `rom_startBit=0`, `rom_addr=0`, `rom_wr_en=0`.
  - `key_out=0`, `key_round=0`, `key_valid=0`.
  - `busy=0`, `done=0`. FSM in IDLE.
- **Key 0 latency:** `start` sampled at edge E0, then REQ E0→E1, WAIT E1→E2. `key_valid=1` after E2, i.e. 2 cycles after the `start` edge.
- **Throughput without prefetch:** 3 cycles per key with `key_ready` held high (REQ, WAIT, HOLD).
- **`busy`:** rises after E0.
- **`done`:** high for exactly one cycle, the cycle after the last transfer edge. `busy` is low from the edge ending that cycle.
- **`rom_wr_en`:** always a single-cycle pulse, separated by at least one low cycle.

## Configuration
- `KEYFETCH_PREFETCH_EN` defined: two-entry key buffer.
  - The next ROM read is issued whenever an entry is free, including while an earlier key is held in HOLD.
  - Keys still leave strictly in order.
  - Steady-state throughput is 2 cycles per key with `key_ready` high.
  - With `key_ready` low, fetch stops once both entries are full: at most 2 keys are buffered, and the strobe count never exceeds transfers+2.
  - `done` rules are unchanged.
- `KEYFETCH_PREFETCH_EN` undefined: single register, the exact FSM above, 3 cycles per key.

## Test plan
- **Reset:** assert `resetn=0` mid-simulation → every output equals its reset value within the same cycle; no `rom_wr_en` pulse while in reset.
- **Basic run:** ROM model with address n holding `{16{n[3:0],4'hA}}`, `start` pulse, `key_ready=1` → 15 transfers. `key_round` runs 0..14 and `key_out` matches the ROM. Key 0 is valid 2 cycles after `start`. `done` pulses once, 45 cycles (no prefetch) after the `start` edge.
- **Backpressure:** `key_ready=0` for 10 cycles on key 3 → key 3 is held stable and valid. No further `rom_wr_en` pulses (no prefetch), or at most one more (prefetch). Release → keys 4..14 arrive in order.
- **Ignored start:** `start` pulsed while `busy` at key 5 → sequence continues unchanged, with exactly 15 transfers and one `done`.
- **Reset mid-run:** reset at key 7, then `start` → fresh sequence starting at `key_round=0`, with a full 15 keys.
- **Parameter edge:** `NUM_KEYS=1` → a single transfer of address 0, then `done`; `rom_addr` never exceeds 0.
